writeback_unit: RTL
===================

// Module: writeback_unit
// PURPOSE
//  Writeback stage directly upstream of the register file. Merges ALU results and
//  load responses into one registered write port (rd/wen/dataD). Holds a per-register
//  busy scoreboard for outstanding loads, used by issue logic for RAW/WAW stalls.
// PARAMETERS
//  ADDR_WIDTH  5   register index width; 1<<ADDR_WIDTH architectural registers
//  DATA_WIDTH  64  register data width
// PORTS
//  clk            in   1           single clock, rising edge
//  rst            in   1           asynchronous, active-high reset
//  alu_valid      in   1           ALU result offered
//  alu_ready      out  1           ALU result accepted this cycle (when alu_valid=1)
//  alu_rd         in   ADDR_WIDTH  ALU destination register
//  alu_data       in   DATA_WIDTH  ALU result
//  lsu_valid      in   1           load response offered (data already extended)
//  lsu_ready      out  1           load response accepted; tied to 1
//  lsu_rd         in   ADDR_WIDTH  load destination register
//  lsu_data       in   DATA_WIDTH  load data
//  issue_ld_valid in   1           a load is issued this cycle; mark issue_ld_rd busy
//  issue_ld_rd    in   ADDR_WIDTH  destination of the issued load
//  rs1, rs2       in   ADDR_WIDTH  source indices queried by issue
//  rs1_busy       out  1           rs1 value not yet readable from register file
//  rs2_busy       out  1           rs2 value not yet readable from register file
//  rf_rd          out  ADDR_WIDTH  to register file rd
//  rf_wen         out  1           to register file wen
//  rf_dataD       out  DATA_WIDTH  to register file dataD
//  wb_err         out  1           sticky: load response to a non-busy register
// BEHAVIOUR
//  - Reset (async, immediate): rf_wen=0, rf_rd=0, rf_dataD=0, wb_err=0, all busy bits 0;
//    a pending write in the output register is discarded.
//  - Arbitration: LSU has priority. lsu_ready=1. alu_ready = !lsu_valid && !busy[alu_rd].
//    ALU result to a register with an outstanding load is held off (WAW) until cleared.
//  - Accept at edge N: source with valid&ready is captured into the output register;
//    rf_wen=1 with rf_rd/rf_dataD during cycle N..N+1; register file writes at edge N+1.
//    One write per cycle; back-to-back accepts give rf_wen high on consecutive cycles.
//  - No accept at an edge: rf_wen=0 next cycle; rf_rd/rf_dataD hold previous values.
//  - rd==0: result is accepted (handshake completes) but rf_wen stays 0.
//  - Scoreboard: at each edge, busy[issue_ld_rd] set if issue_ld_valid && rd!=0;
//    busy[lsu_rd] cleared on LSU accept. Same register set and cleared at one edge:
//    set wins (new load outstanding). busy[0] is constantly 0.
//  - LSU accept with busy[lsu_rd]==0: write still performed, wb_err set, held to reset.
//  - rsN_busy (combinational) = busy[rsN] | (rf_wen && rf_rd==rsN && rsN!=0);
//    covers the cycle in which the write sits in the output register. rsN==0 -> 0.
//  - Busy is NOT a forwarding path; issue stalls while rsN_busy=1.
// CONFIGURATION
//  WB_TRACE_EN defined: on every edge with rf_wen=1 and rf_rd!=0, $display
//    "wb x<rd> <= 0x<data> (<alu|lsu>)"; source tag kept in a 1-bit register under the macro.
//  WB_TRACE_EN undefined: no display statements, no tag register; ports and timing identical.
// TESTING
//  1. Reset, ALU x5=0x1234 valid one cycle -> alu_ready=1; next cycle rf_wen=1, rf_rd=5,
//     rf_dataD=0x1234; following cycle rf_wen=0.
//  2. ALU x3 and LSU x4 valid same cycle (x4 busy) -> alu_ready=0, LSU written first;
//     ALU x3 written on the next cycle; busy[4] cleared; wb_err=0.
//  3. issue_ld x7; then ALU x7 valid -> alu_ready=0 and rs1_busy=1 for rs1=7 until LSU x7
//     accepted; ALU x7 accepted next cycle, so the final value is the ALU data.
//  4. ALU x0=0xFFFF -> alu_ready=1, rf_wen stays 0; issue_ld x0 -> busy stays 0.
//  5. issue_ld x9 and LSU x9 response at same edge -> busy[9]=1 after edge;
//     LSU x2 with busy[2]=0 -> x2 written, wb_err=1 and stays 1.
//  6. Assert rst mid-cycle while rf_wen=1 and busy[6]=1 -> rf_wen, busy, wb_err drop
//     to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage feeding the register file write port.
// Merges ALU results and load responses into one registered write
// (LSU has priority) and keeps a per-register busy scoreboard of
// outstanding loads for issue-side RAW/WAW stalls.
// Optional build macro: WB_TRACE_EN (prints every committed write).
module writeback_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  issue_ld_valid,
    input  logic [ADDR_WIDTH-1:0] issue_ld_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic                  rf_wen,
    output logic [DATA_WIDTH-1:0] rf_dataD,
    output logic                  wb_err
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            lsu_acc;
    logic            alu_acc;

    // Load responses are never back-pressured; the ALU yields to them and
    // waits while its destination still has a load outstanding (WAW).
    assign lsu_ready = 1'b1;
    assign lsu_acc   = lsu_valid;
    assign alu_ready = !lsu_valid && !busy[alu_rd];
    assign alu_acc   = alu_valid && alu_ready;

    // A source is also busy while its write sits in the output register,
    // because the register file only commits it at the following edge.
    assign rs1_busy = (rs1 != '0) && (busy[rs1] || (rf_wen && rf_rd == rs1));
    assign rs2_busy = (rs2 != '0) && (busy[rs2] || (rf_wen && rf_rd == rs2));

    // Next scoreboard: clear on load writeback, then set on new load issue.
    always_comb begin
        // NOTE: default assignment first so every path drives busy_next and no latch is inferred.
        busy_next = busy;
        if (lsu_acc) begin
            busy_next[lsu_rd] = 1'b0;
        end
        // Applied after the clear so a same-edge issue keeps the register busy.
        if (issue_ld_valid && issue_ld_rd != '0) begin
            busy_next[issue_ld_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the scoreboard is a flop vector, not a RAM, so it can and must be reset.
            busy   <= '0;
            wb_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            busy <= busy_next;
            if (lsu_acc && !busy[lsu_rd]) begin
                wb_err <= 1'b1;
            end
        end
    end

    // Output write register; rd/data hold when nothing is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_rd    <= '0;
            rf_dataD <= '0;
        end else if (lsu_acc) begin
            rf_wen <= (lsu_rd != '0);
            if (lsu_rd != '0) begin
                rf_rd    <= lsu_rd;
                rf_dataD <= lsu_data;
            end
        end else if (alu_acc) begin
            rf_wen <= (alu_rd != '0);
            if (alu_rd != '0) begin
                rf_rd    <= alu_rd;
                rf_dataD <= alu_data;
            end
        end else begin
            rf_wen <= 1'b0;
        end
    end

`ifdef WB_TRACE_EN
    logic src_lsu;

    // Remember which source produced the write held in the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_lsu <= 1'b0;
        end else if (lsu_acc || alu_acc) begin
            src_lsu <= lsu_acc;
        end
    end

    // Report each write as the register file commits it.
    always @(posedge clk) begin
        if (!rst && rf_wen && rf_rd != '0) begin
            $display("wb x%0d <= 0x%h (%s)", rf_rd, rf_dataD, src_lsu ? "lsu" : "alu");
        end
    end
`endif

endmodule
